// File: rtl/arb_pkg.sv
// Shared types and defaults for the weighted round-robin packet arbiter.
package arb_pkg;

   localparam int unsigned N_DEF        = 8;
   localparam int unsigned WEIGHT_W_DEF = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority find-first: first set bit of req at or above ptr, wrapping to 0.
module rr_priority_picker #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int pos;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      pos    = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (!any && req[IDX_W'(pos)]) begin
            any                 = 1'b1;
            idx                 = IDX_W'(pos);
            onehot[IDX_W'(pos)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin arbiter that locks a grant for a whole multi-beat packet.
module wrr_packet_arbiter
   import arb_pkg::*;
#(
   parameter  int N        = N_DEF,
   parameter  int WEIGHT_W = WEIGHT_W_DEF,
   localparam int IDX_W    = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic [N-1:0]          req_is_last,
   input  logic [N*WEIGHT_W-1:0] weight,
   input  logic                  accept,
   output logic [N-1:0]          grants,
   output logic [IDX_W-1:0]      owner_idx,
   output logic                  busy,
   output logic                  pkt_done
);

   arb_state_e          state_q;
   logic [N-1:0]        grants_q;
   logic [IDX_W-1:0]    owner_q;
   logic                busy_q;
   logic                done_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [WEIGHT_W-1:0] cnt_q;
   logic [WEIGHT_W-1:0] eff_w_q;

   logic [N-1:0]        pick_onehot;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic [WEIGHT_W-1:0] w_arr [N];
   logic [WEIGHT_W-1:0] win_eff_w;
   logic                last_xfer;
   logic [WEIGHT_W:0]   cnt_inc;
   logic                quota_hit;
   logic [IDX_W-1:0]    ptr_inc;

   rr_priority_picker #(.N(N), .IDX_W(IDX_W)) u_picker (
      .req    (req),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   for (genvar i = 0; i < N; i++) begin : g_weight
      assign w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
   end

   // A programmed weight of zero still earns one packet per turn.
   assign win_eff_w = (w_arr[pick_idx] == '0) ? WEIGHT_W'(1) : w_arr[pick_idx];
   assign last_xfer = (state_q == ST_LOCKED) && accept && req[owner_q] && req_is_last[owner_q];
   assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
   assign quota_hit = cnt_inc >= {1'b0, eff_w_q};
   assign ptr_inc   = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + 1'b1;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         grants_q <= '0;
         owner_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         eff_w_q  <= WEIGHT_W'(1);
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  state_q  <= ST_LOCKED;
                  grants_q <= pick_onehot;
                  owner_q  <= pick_idx;
                  busy_q   <= 1'b1;
                  eff_w_q  <= win_eff_w;
                  if (pick_idx != ptr_q) begin
                     ptr_q <= pick_idx;
                     cnt_q <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (last_xfer) begin
                  state_q  <= ST_IDLE;
                  grants_q <= '0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  if (quota_hit) begin
                     ptr_q <= ptr_inc;
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_inc[WEIGHT_W-1:0];
                  end
               end
            end
         endcase
      end
   end

   assign grants    = grants_q;
   assign owner_idx = owner_q;
   assign busy      = busy_q;
   assign pkt_done  = done_q;

endmodule

// File: doc/wrr_packet_arbiter.md
WRR_PACKET_ARBITER -- requirements
Module: wrr_packet_arbiter

Interface
REQ-001 SHALL have parameter N, default 8: number of requesters, 2..32.
REQ-002 SHALL have parameter WEIGHT_W, default 4: width of each per-requester weight field.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, N: per-requester "beat pending" flags.
REQ-006 SHALL have port req_is_last, input, N: current beat of requester i is the last beat of its packet; ignored when req[i]=0.
REQ-007 SHALL have port weight, input, N*WEIGHT_W: packets per turn, requester i at bits [i*WEIGHT_W +: WEIGHT_W]; value 0 treated as 1.
REQ-008 SHALL have port accept, input, 1: downstream takes the granted beat this cycle.
REQ-009 SHALL have port grants, output, N: registered one-hot (or zero) grant vector.
REQ-010 SHALL have port owner_idx, output, $clog2(N): index of the current grant holder; valid while busy=1.
REQ-011 SHALL have port busy, output, 1: a packet is locked.
REQ-012 SHALL have port pkt_done, output, 1: registered pulse, one cycle after the last beat of a packet is transferred.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-014 SHALL, in IDLE with any req bit set, select the winner by rotating priority starting at index ptr and searching upward with wrap.
REQ-015 SHALL, at the next edge after selection: set grants to the winner's one-hot value, set busy=1, load owner_idx, and enter LOCKED; grant latency from req is 1 cycle.
REQ-016 SHALL remain in IDLE with grants=0 when req=0.
REQ-017 SHALL define a beat transfer as: LOCKED & accept & req[owner_idx].
REQ-018 SHALL hold grants unchanged in LOCKED until a transfer with req_is_last[owner_idx]=1 occurs.
REQ-019 SHALL keep the lock while the owner deasserts req mid-packet; no other requester is granted.
REQ-020 SHALL, on the last-beat transfer: clear grants, clear busy, return to IDLE, and pulse pkt_done the following cycle.
REQ-021 SHALL leave one idle bubble cycle between consecutive packets.
REQ-022 SHALL keep a quota counter cnt (WEIGHT_W bits) and a latched effective weight eff_w, captured from weight at grant time.
REQ-023 SHALL, at a grant where winner != ptr: set ptr to winner and cnt to 0.
REQ-024 SHALL, on the last-beat transfer, increment cnt; if cnt+1 >= eff_w, set ptr to owner+1 (wrap to 0 after N-1) and cnt to 0.
REQ-025 SHALL ignore changes to the weight input during LOCKED.
REQ-026 SHALL give accept no effect outside LOCKED.
REQ-027 SHALL never drive more than one grant bit high.

Reset
REQ-028 SHALL, on rst=1 at a clock edge: state=IDLE, grants=0, busy=0, owner_idx=0, pkt_done=0, ptr=0, cnt=0, eff_w=1.
REQ-029 SHALL, when reset occurs mid-packet, abandon the packet with no pkt_done pulse.
REQ-030 SHALL give rst priority over all other inputs in the same cycle.

Structure
REQ-031 SHALL place the FSM state enum, default N, and default WEIGHT_W in package arb_pkg.
REQ-032 SHALL implement the rotating-priority find-first as combinational sub-module rr_priority_picker (inputs req, ptr; outputs onehot, idx, any).

Verification
REQ-033 SHALL cover weights: weight all 1, req=8'b10011011, each requester sends 1-beat packets (req_is_last=req), accept=1 -> grant order 0,1,3,4,7,0, with a grant every 2nd cycle.
REQ-034 SHALL cover quota: weight[0]=3, others 1, req=8'b00000011, 1-beat packets -> grants 0,0,0,1,0,0,0,1.
REQ-035 SHALL cover lock and stall: owner 2, 3-beat packet, accept low for 2 cycles, req[5]=1 throughout -> grants stays 8'b00000100 until the 3rd accepted beat; pkt_done pulses once; then grants=8'b00100000.
REQ-036 SHALL cover wrap: ptr=7, req=8'b10000001, weight 1 -> grant 7, then 0, then 7.
REQ-037 SHALL cover reset mid-packet: rst asserted in LOCKED -> next cycle grants=0, busy=0, pkt_done=0; a following req=8'b00010000 is granted to index 4 with ptr starting at 0.
REQ-038 SHALL cover weight 0: weight[1]=0, req=8'b00000010 with req[3] also set -> requester 1 gets exactly 1 packet, then 3 is granted.
